// File: rtl/psg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psg_pkg
// Description : Shared PSG register map, write-entry type and sequencer
//               state encoding for the PSG register-write path.
// Revision    : 1.0 - initial release
// ============================================================================
package psg_pkg;

    // PSG register indices
    localparam logic [3:0] REG_TONE_A_LO = 4'd0;
    localparam logic [3:0] REG_TONE_A_HI = 4'd1;
    localparam logic [3:0] REG_TONE_B_LO = 4'd2;
    localparam logic [3:0] REG_TONE_B_HI = 4'd3;
    localparam logic [3:0] REG_TONE_C_LO = 4'd4;
    localparam logic [3:0] REG_TONE_C_HI = 4'd5;
    localparam logic [3:0] REG_NOISE     = 4'd6;
    localparam logic [3:0] REG_MIXER     = 4'd7;
    localparam logic [3:0] REG_AMP_A     = 4'd8;
    localparam logic [3:0] REG_AMP_B     = 4'd9;
    localparam logic [3:0] REG_AMP_C     = 4'd10;
    localparam logic [3:0] REG_ENV_LO    = 4'd11;
    localparam logic [3:0] REG_ENV_HI    = 4'd12;
    localparam logic [3:0] REG_ENV_SHAPE = 4'd13;

    // Register 14 is unused by the PSG, so addressing it is harmless filler
    localparam logic [3:0] REG_IDLE      = 4'hE;

    // Value driven on the DATA cycle of an idle pair
    localparam logic [7:0] BUS_IDLE_DATA = 8'h00;

    // One queued register write
    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } psg_write_t;

    localparam int WRITE_BITS = $bits(psg_write_t);

    // Sequencer state, decided at every edge that begins an ADDR cycle
    typedef enum logic {
        IDLE_PAIR  = 1'b0,
        WRITE_PAIR = 1'b1
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/psg_write_fifo.sv
`default_nettype none
// ============================================================================
// Module      : psg_write_fifo
// Description : Synchronous FIFO for queued PSG writes. Push is ignored when
//               full, pop is ignored when empty; push and pop on the same
//               edge both take effect and leave the occupancy unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module psg_write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Occupancy next-state: simultaneous push and pop cancel out
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Entry storage; contents beyond the occupancy are don't-care, so no reset
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/psg_register_writer.sv
`default_nettype none
// ============================================================================
// Module      : psg_register_writer
// Description : Drives the PSG register-write port from a valid/ready stream
//               of (addr, data) writes. Stays phase-locked with the PSG's
//               ADDR/DATA alternation and fills empty slots with a write
//               pair aimed at unused register 14.
// Revision    : 1.0 - initial release
// ============================================================================
module psg_register_writer
    import psg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int COUNT_BITS = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    input  logic [3:0]            in_addr_i,
    input  logic [7:0]            in_data_i,
    output logic                  in_ready_o,
    output logic [7:0]            bus_out_o,
    output logic                  idle_o,
    output logic [COUNT_BITS-1:0] writes_done_o
);

    // phase_q: 0 = DATA cycle in progress, 1 = ADDR cycle in progress
    logic                  phase_q;
    seq_state_t            state_q;
    seq_state_t            state_d;
    logic [7:0]            bus_q;
    logic [7:0]            bus_d;
    logic [7:0]            pending_data_q;
    logic [7:0]            pending_data_d;
    logic [COUNT_BITS-1:0] writes_done_q;
    logic [COUNT_BITS-1:0] writes_done_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    psg_write_t            fifo_head;
    psg_write_t            in_entry;

    assign in_entry   = '{addr: in_addr_i, data: in_data_i};
    assign fifo_push  = in_valid_i && !fifo_full;

    psg_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WRITE_BITS)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (fifo_push),
        .push_data_i (in_entry),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign in_ready_o    = !fifo_full;
    assign idle_o        = fifo_empty && (state_q == IDLE_PAIR);
    assign bus_out_o     = bus_q;
    assign writes_done_o = writes_done_q;

    // Sequencer: pick the next pair at the DATA->ADDR edge, finish it at ADDR->DATA
    always_comb begin
        state_d        = state_q;
        bus_d          = bus_q;
        pending_data_d = pending_data_q;
        writes_done_d  = writes_done_q;
        fifo_pop       = 1'b0;
        if (!phase_q) begin
            // A DATA cycle is ending; if it carried a real write it is now done
            if (state_q == WRITE_PAIR) begin
                writes_done_d = writes_done_q + COUNT_BITS'(1);
            end
            if (!fifo_empty) begin
                fifo_pop       = 1'b1;
                bus_d          = {4'h0, fifo_head.addr};
                pending_data_d = fifo_head.data;
                state_d        = WRITE_PAIR;
            end else begin
                bus_d   = {4'h0, REG_IDLE};
                state_d = IDLE_PAIR;
            end
        end else begin
            bus_d = (state_q == WRITE_PAIR) ? pending_data_q : BUS_IDLE_DATA;
        end
    end

    // State registers; reset aligns phase with the PSG's own reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            phase_q        <= 1'b0;
            state_q        <= IDLE_PAIR;
            bus_q          <= 8'h00;
            pending_data_q <= 8'h00;
            writes_done_q  <= '0;
        end else begin
            phase_q        <= ~phase_q;
            state_q        <= state_d;
            bus_q          <= bus_d;
            pending_data_q <= pending_data_d;
            writes_done_q  <= writes_done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psg_register_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_psg_register_writer
// Description : Self-checking bench for psg_register_writer. A transaction
//               level model (queue of accepted writes + alternating pair
//               schedule) predicts every output each cycle; a PSG observer
//               consumes the DUT bus like the real core would.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psg_register_writer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_addr;
    logic [7:0]  in_data;

    logic        ready_a, idle_a, ready_b, idle_b;
    logic [7:0]  bus_a, bus_b;
    logic [15:0] wd_a;
    logic [3:0]  wd_b;

    always #5 clk = ~clk;

    psg_register_writer #(.FIFO_DEPTH(DEPTH), .COUNT_BITS(16)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_valid_i    (in_valid),
        .in_addr_i     (in_addr),
        .in_data_i     (in_data),
        .in_ready_o    (ready_a),
        .bus_out_o     (bus_a),
        .idle_o        (idle_a),
        .writes_done_o (wd_a)
    );

    psg_register_writer #(.FIFO_DEPTH(DEPTH), .COUNT_BITS(4)) dut4 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_valid_i    (in_valid),
        .in_addr_i     (in_addr),
        .in_data_i     (in_data),
        .in_ready_o    (ready_b),
        .bus_out_o     (bus_b),
        .idle_o        (idle_b),
        .writes_done_o (wd_b)
    );

    // Transaction model: waiting writes, the pair on the bus, and the count
    logic [11:0] mq [$];
    bit          m_is_addr;      // current cycle is an ADDR cycle
    bit          m_busy;         // current pair is a real write
    logic [11:0] m_cur;
    logic [7:0]  m_bus;
    int unsigned m_done;

    // PSG observer driven by the DUT bus
    logic [7:0]  ob_regs [16];
    logic [3:0]  ob_latch;
    bit          ob_is_addr;
    logic [7:0]  ob_last_bus;
    logic [11:0] ob_log [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance observer and model at the edge, compare
    task automatic cycle(input bit v, input logic [3:0] a, input logic [7:0] d,
                         input bit rn, output bit acc);
        logic [11:0] seen;
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        rst_n    = rn;
        acc      = rn && v && (mq.size() < DEPTH);
        seen     = 12'h000;
        @(posedge clk);
        if (!rn) begin
            foreach (ob_regs[i]) ob_regs[i] = 8'h00;
            ob_latch   = 4'h0;
            ob_is_addr = 1'b0;
        end else begin
            if (ob_is_addr) begin
                ob_latch = ob_last_bus[3:0];
            end else begin
                seen = {ob_latch, ob_last_bus};
                if (ob_latch < 4'd14) ob_regs[ob_latch] = ob_last_bus;
            end
            ob_is_addr = !ob_is_addr;
        end
        if (!rn) begin
            mq.delete();
            m_is_addr = 1'b0;
            m_busy    = 1'b0;
            m_bus     = 8'h00;
            m_done    = 0;
        end else begin
            if (!m_is_addr) begin
                if (m_busy) begin
                    m_done++;
                    chk("order", seen, m_cur);
                    ob_log.push_back(seen);
                end
                if (mq.size() != 0) begin
                    m_cur  = mq.pop_front();
                    m_busy = 1'b1;
                    m_bus  = {4'h0, m_cur[11:8]};
                end else begin
                    m_busy = 1'b0;
                    m_bus  = 8'h0E;
                end
            end else begin
                m_bus = m_busy ? m_cur[7:0] : 8'h00;
            end
            if (acc) mq.push_back({a, d});
            m_is_addr = !m_is_addr;
        end
        #1;
        chk("bus",    bus_a,  m_bus);
        chk("bus4",   bus_b,  m_bus);
        chk("ready",  ready_a, (mq.size() < DEPTH));
        chk("ready4", ready_b, (mq.size() < DEPTH));
        chk("idle",   idle_a, (mq.size() == 0) && !m_busy);
        chk("idle4",  idle_b, (mq.size() == 0) && !m_busy);
        chk("wdone",  wd_a,   m_done[15:0]);
        chk("wdone4", wd_b,   m_done[3:0]);
        ob_last_bus = bus_a;
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 60; k++) begin
            if (idle_a && mq.size() == 0 && !m_busy) break;
            cycle(1'b0, 4'h0, 8'h00, 1'b1, acc);
        end
        chk("drain_idle", idle_a, 1'b1);
    endtask

    task automatic do_reset(input int n);
        bit acc;
        for (int k = 0; k < n; k++) cycle(1'b0, 4'h0, 8'h00, 1'b0, acc);
    endtask

    initial begin
        bit          acc;
        bit          saw_low;
        int          i;
        int          changed;
        logic [7:0]  rseq [3];
        logic [7:0]  wseq [5];
        logic [7:0]  snap [16];

        in_valid    = 1'b0;
        in_addr     = 4'h0;
        in_data     = 8'h00;
        rst_n       = 1'b0;
        ob_last_bus = 8'h00;
        m_cur       = 12'h000;

        // Reset: three cycles low, then idle pattern 00,0E,00,0E
        do_reset(3);
        chk("rst_bus",   bus_a,   8'h00);
        chk("rst_ready", ready_a, 1'b1);
        chk("rst_idle",  idle_a,  1'b1);
        chk("rst_wd",    wd_a,    16'h0);
        rseq = '{8'h0E, 8'h00, 8'h0E};
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 4'h0, 8'h00, 1'b1, acc);
            chk("rst_seq", bus_a, rseq[k]);
        end

        // Single write (8, 1F) on the first cycle after reset
        do_reset(1);
        wseq = '{8'h0E, 8'h00, 8'h08, 8'h1F, 8'h0E};
        cycle(1'b1, 4'h8, 8'h1F, 1'b1, acc);
        chk("single_bus0", bus_a, wseq[0]);
        for (int k = 1; k < 5; k++) begin
            cycle(1'b0, 4'h0, 8'h00, 1'b1, acc);
            chk("single_bus", bus_a, wseq[k]);
        end
        chk("single_wd",   wd_a, 16'd1);
        chk("single_ampA", ob_regs[8][3:0], 4'hF);
        chk("single_reg8", ob_regs[8], 8'h1F);

        // Burst of 6 with valid held high
        do_reset(1);
        ob_log.delete();
        i = 0;
        saw_low = 1'b0;
        for (int k = 0; k < 60 && i < 6; k++) begin
            cycle(1'b1, 4'(i), 8'hA0 + 8'(i), 1'b1, acc);
            if (acc) i++;
            if (!ready_a) saw_low = 1'b1;
        end
        drain();
        chk("burst_ready_low", saw_low, 1'b1);
        chk("burst_wd", wd_a, 16'd6);
        chk("burst_log_n", ob_log.size(), 6);
        for (int k = 0; k < 6 && k < ob_log.size(); k++)
            chk("burst_log", ob_log[k], {4'(k), 8'hA0 + 8'(k)});

        // Longer held burst: pushes keep arriving while a full queue pops
        do_reset(1);
        ob_log.delete();
        i = 0;
        for (int k = 0; k < 80 && i < 10; k++) begin
            cycle(1'b1, 4'(i), 8'h30 + 8'(i), 1'b1, acc);
            if (acc) i++;
        end
        drain();
        chk("full_wd", wd_a, 16'd10);
        chk("full_log_n", ob_log.size(), 10);
        for (int k = 0; k < 10 && k < ob_log.size(); k++)
            chk("full_log", ob_log[k], {4'(k), 8'h30 + 8'(k)});

        // Reset during the DATA cycle of a write to register 12
        do_reset(1);
        cycle(1'b1, 4'd12, 8'h55, 1'b1, acc);
        for (int k = 0; k < 10; k++) begin
            if (m_busy && !m_is_addr) break;
            cycle(1'b0, 4'h0, 8'h00, 1'b1, acc);
        end
        chk("midrst_data_on_bus", bus_a, 8'h55);
        do_reset(1);
        chk("midrst_wd",    wd_a,    16'd0);
        chk("midrst_idle",  idle_a,  1'b1);
        chk("midrst_ready", ready_a, 1'b1);
        cycle(1'b0, 4'h0, 8'h00, 1'b1, acc);
        chk("midrst_bus0E", bus_a, 8'h0E);
        cycle(1'b0, 4'h0, 8'h00, 1'b1, acc);
        chk("midrst_bus00", bus_a, 8'h00);
        chk("midrst_reg12", ob_regs[12], 8'h00);

        // 17 writes: 4-bit counter wraps to 1; then a host write to reg 14
        do_reset(1);
        i = 0;
        for (int k = 0; k < 200 && i < 17; k++) begin
            cycle(1'b1, 4'(i % 14), 8'(i), 1'b1, acc);
            if (acc) i++;
        end
        drain();
        chk("wrap_wd4", wd_b, 4'd1);
        chk("wrap_wd",  wd_a, 16'd17);
        foreach (snap[k]) snap[k] = ob_regs[k];
        cycle(1'b1, 4'd14, 8'hFF, 1'b1, acc);
        drain();
        changed = 0;
        foreach (snap[k]) if (snap[k] !== ob_regs[k]) changed++;
        chk("reg14_regs_unchanged", changed, 0);
        chk("reg14_wd",  wd_a, 16'd18);
        chk("reg14_wd4", wd_b, 4'd2);

        // Randomised traffic with occasional resets
        do_reset(2);
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  8'($urandom_range(0, 255)), ($urandom_range(0, 299) != 0), acc);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psg_register_writer.md
# psg_register_writer

Bus-side sequencer that drives the PSG's 8-bit register-write port (`ui_in`) from a valid/ready stream of (address, data) register writes. The PSG alternates address-latch and data-write cycles from reset, and writes on every data cycle; this block queues requests, keeps phase-lock with that alternation, and drives a harmless idle pattern when it has nothing to send. It sits between a host/sequencer (e.g. a music-player ROM walker) and the PSG core, sharing its clock and reset.

## Interface
- `FIFO_DEPTH`, 4, request queue entries; power of two, ≥2.
- `COUNT_BITS`, 16, width of `writes_done`.
- `clk` input 1, sole clock; same clock as the PSG core.
- `rst_n` input 1, synchronous, active-low reset; must be the same reset as the PSG core.
- `in_valid` input 1, request present.
- `in_addr` input 4, PSG register index 0–15.
- `in_data` input 8, register value.
- `in_ready` output 1, request accepted on a cycle where `in_valid && in_ready`.
- `bus_out` output 8, drives PSG `ui_in`.
- `idle` output 1, queue empty and no write in flight.
- `writes_done` output COUNT_BITS, completed-write count, wraps.

## Operation
- Phase register `phase`: 0 = DATA cycle (PSG writes `ui_in` into its latched register), 1 = ADDR cycle (PSG latches `ui_in[3:0]`). Resets to 0, toggles every cycle, matching the PSG's internal latch toggle.
- Two-state sequencer: IDLE_PAIR, WRITE_PAIR, decided at each edge that begins an ADDR cycle.
  - Queue non-empty: pop head, `bus_out <= {4'h0, addr}`, hold data in `pending_data`, state WRITE_PAIR. Next DATA cycle: `bus_out <= pending_data`; `writes_done` increments at the end of that DATA cycle.
  - Queue empty: `bus_out <= 8'h0E` (unused register 14), then DATA cycle `bus_out <= 8'h00`; state IDLE_PAIR. The PSG ignores register 14, so idle traffic has no effect.
- Addresses 14/15 from the host pass through unchanged; they are PSG no-ops but count in `writes_done`.
- Queue: FIFO of {addr, data}, 12 bits/entry. `in_ready = !full`. Push and pop in the same cycle both happen; count unchanged.
- `idle = empty && state == IDLE_PAIR`.
- `writes_done` wraps from all-ones to 0.
- Write order to the PSG equals acceptance order; no merging or reordering.

## Timing
- Reset values: `bus_out = 8'h00`, `phase = 0`, `in_ready = 1`, `idle = 1`, `writes_done = 0`, queue empty, state IDLE_PAIR.
- First cycle after `rst_n` rises is a DATA cycle with `bus_out = 8'h00`; this writes 0 to PSG register 0, which equals its reset value.
- `bus_out` is registered; all outputs are glitch-free from flops except `in_ready` and `idle` (decoded from flops only).
- Latency: a request accepted at edge E with an empty queue appears as ADDR at the next ADDR-cycle edge after E (1 or 2 cycles), DATA on the cycle after. Minimum accept-to-DATA: 2 cycles; worst: 3.
- Sustained throughput: one write per 2 cycles; the host can sustain this with `in_valid` held high.
- Full queue: `in_ready` low; it rises the cycle after the pop at an ADDR edge.
- Reset mid-operation: queue flushed, in-flight write dropped (not counted), all state returns to reset values on the reset edge. The PSG resets in the same cycle, so phase lock is preserved.

## Structure
- Shared package `psg_pkg`: register index constants (`REG_TONE_A_LO` … `REG_ENV_SHAPE` = 0…13), `REG_IDLE = 4'hE`, write-entry typedef (4-bit addr + 8-bit data).
- Sub-module `psg_write_fifo`: parameterised synchronous FIFO with push/pop, full/empty, and simultaneous push/pop.
- Top level holds the phase flop, sequencer, `pending_data`, and counter.

## Test plan
- Reset: hold `rst_n`=0 3 cycles, release → `bus_out` sequence 00,0E,00,0E…; `idle`=1, `in_ready`=1, `writes_done`=0.
- Single write (addr 8, data 0x1F) pulsed on cycle 0 after reset → ADDR cycle shows 0x08, next DATA shows 0x1F; `writes_done`=1; PSG model `amplitude_A`=0xF, `mute_A`=1.
- Burst of 6 writes (addr 0–5, data 0xA0+i) with `in_valid` held high, `FIFO_DEPTH`=4 → `in_ready` drops once full, all 6 appear in order as 0i/A(i) pairs, `writes_done`=6, then `idle` returns to 1.
- Push during a pop on a full queue → no entry lost or duplicated; the order checked against a scoreboard.
- Reset asserted during the DATA cycle of a write to addr 12 → the write is not completed, `writes_done`=0, the queue is empty, and the bus returns to 00/0E.
- `COUNT_BITS`=4, 17 writes → `writes_done` wraps to 1; a host write to addr 14 is counted and leaves all PSG registers unchanged.
